// File: rtl/attn_score_row_prep_if.sv
// Stream bundle for attn_score_row_prep: raw score input and (score - row_max) output.
interface attn_score_row_prep_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned HEAD_W = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic signed [DATA_W-1:0] out_max;
    logic                     out_last;
    logic [HEAD_W-1:0]        out_head;
    logic                     frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_max, out_last, out_head, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_max, out_last, out_head, frame_done
    );
endinterface

// File: rtl/attn_score_row_prep.sv
// Scales one attention-score row, buffers it, and re-emits it as (score - row_max) for softmax.
// Define SCORE_ROUND_EN for round-half-up scaling instead of truncating arithmetic shift.
module attn_score_row_prep #(
    parameter int unsigned SEQ_LENGTH  = 512,
    parameter int unsigned NUM_HEADS   = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SCALE_SHIFT = 3
) (
    input logic                  clk,
    input logic                  reset,
    attn_score_row_prep_if.slave bus
);
    localparam int unsigned COL_W  = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;
    localparam int unsigned HEAD_W = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam logic [COL_W-1:0]  ColLast  = COL_W'(SEQ_LENGTH - 1);
    localparam logic [HEAD_W-1:0] HeadLast = HEAD_W'(NUM_HEADS - 1);
    localparam logic signed [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {StFill, StDrainRd, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [COL_W-1:0]         row_q, row_d;
    logic [HEAD_W-1:0]        head_q, head_d;
    logic signed [DATA_W-1:0] row_max_q, row_max_d;

    logic signed [DATA_W-1:0] row_buf [SEQ_LENGTH];
    logic signed [DATA_W-1:0] rd_data_q;
    logic [COL_W-1:0]         rd_addr;

    logic                     in_fire, out_fire;
    logic                     col_last, row_last, head_last;
    logic signed [DATA_W-1:0] scaled;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W-1:0] diff_sat;

    assign in_fire   = bus.in_valid && (state_q == StFill);
    assign out_fire  = bus.out_ready && (state_q == StDrain);
    assign col_last  = (col_q == ColLast);
    assign row_last  = (row_q == ColLast);
    assign head_last = (head_q == HeadLast);

`ifdef SCORE_ROUND_EN
    localparam logic signed [DATA_W:0] RoundHalf = (DATA_W+1)'(1) << (SCALE_SHIFT - 1);

    logic signed [DATA_W:0]   rnd_sum;
    logic signed [DATA_W-1:0] rnd_sat;

    always_comb begin
        rnd_sum = {bus.in_data[DATA_W-1], bus.in_data} + RoundHalf;
        // Only positive overflow is possible when adding a positive constant.
        if (!rnd_sum[DATA_W] && rnd_sum[DATA_W-1]) begin
            rnd_sat = MaxPos;
        end else begin
            rnd_sat = rnd_sum[DATA_W-1:0];
        end
        scaled = rnd_sat >>> SCALE_SHIFT;
    end
`else
    assign scaled = $signed(bus.in_data) >>> SCALE_SHIFT;
`endif

    // Wide subtract with a saturation guard; unreachable for SCALE_SHIFT >= 1.
    always_comb begin
        diff = {rd_data_q[DATA_W-1], rd_data_q} - {row_max_q[DATA_W-1], row_max_q};
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            diff_sat = diff[DATA_W] ? MinNeg : MaxPos;
        end else begin
            diff_sat = diff[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        head_d    = head_q;
        row_max_d = row_max_q;
        rd_addr   = col_q;
        case (state_q)
            StFill: begin
                if (in_fire) begin
                    if ((col_q == '0) || (scaled > row_max_q)) begin
                        row_max_d = scaled;
                    end
                    if (col_last) begin
                        col_d   = '0;
                        state_d = StDrainRd;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrainRd: begin
                state_d = StDrain;
            end
            StDrain: begin
                // Prefetch the next element on each handshake so a full-rate drain has no bubbles.
                if (out_fire) begin
                    if (col_last) begin
                        col_d   = '0;
                        rd_addr = '0;
                        state_d = StFill;
                        if (row_last) begin
                            row_d  = '0;
                            head_d = head_last ? '0 : head_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        rd_addr = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFill;
            col_q     <= '0;
            row_q     <= '0;
            head_q    <= '0;
            row_max_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            head_q    <= head_d;
            row_max_q <= row_max_d;
        end
    end

    // Row buffer with a registered read port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            row_buf[col_q] <= scaled;
        end
        rd_data_q <= row_buf[rd_addr];
    end

    assign bus.in_ready   = (state_q == StFill);
    assign bus.out_valid  = (state_q == StDrain);
    assign bus.out_data   = (state_q == StDrain) ? diff_sat : '0;
    assign bus.out_max    = row_max_q;
    assign bus.out_last   = (state_q == StDrain) && col_last;
    assign bus.out_head   = head_q;
    assign bus.frame_done = !reset && out_fire && col_last && row_last && head_last;

    a_out_nonpos: assert property (@(posedge clk) disable iff (reset)
        bus.out_valid |-> (bus.out_data <= 0));

    a_out_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));
endmodule

// File: tb/tb_attn_score_row_prep.sv
// Directed self-checking bench for attn_score_row_prep (SEQ_LENGTH=4, NUM_HEADS=2, SCALE_SHIFT=2).
module tb_attn_score_row_prep;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    attn_score_row_prep_if #(.DATA_W(DW), .HEAD_W(1)) bus ();

    attn_score_row_prep #(
        .SEQ_LENGTH (4),
        .NUM_HEADS  (2),
        .DATA_W     (DW),
        .SCALE_SHIFT(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] got_data [4];
    logic signed [DW-1:0] got_max  [4];
    logic                 got_last [4];
    logic                 got_head [4];
    logic                 got_fd   [4];
    int first_cyc;
    int acc_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_row(input logic signed [DW-1:0] d0, d1, d2, d3);
        logic signed [DW-1:0] v [4];
        v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3;
        for (int i = 0; i < 4; i++) begin
            int guard;
            guard        = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            #1;
            while (!bus.in_ready && guard < 50) begin
                step();
                #1;
                guard++;
            end
            if (!bus.in_ready) begin
                tests++;
                fails++;
                $display("FAIL push_timeout elem %0d: in_ready got 0 want 1", i);
            end
            acc_cyc = cyc;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n, input int start);
        for (int k = 0; k < n; k++) begin
            int guard;
            guard         = 0;
            bus.out_ready = 1'b1;
            #1;
            while (!bus.out_valid && guard < 50) begin
                step();
                #1;
                guard++;
            end
            if (!bus.out_valid) begin
                tests++;
                fails++;
                $display("FAIL pop_timeout elem %0d: out_valid got 0 want 1", start + k);
            end
            if (start + k == 0) first_cyc = cyc;
            got_data[start+k] = bus.out_data;
            got_max[start+k]  = bus.out_max;
            got_last[start+k] = bus.out_last;
            got_head[start+k] = bus.out_head;
            got_fd[start+k]   = bus.frame_done;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL rst_out_data got %0d want 0", bus.out_data); end
        tests++; if (bus.out_max !== '0) begin fails++; $display("FAIL rst_out_max got %0d want 0", bus.out_max); end
        tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
        tests++; if (bus.out_head !== 1'b0) begin fails++; $display("FAIL rst_out_head got %b want 0", bus.out_head); end
        tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
        step();
    endtask

    task automatic test_basic_row();
        logic signed [DW-1:0] exp_d [4];
        exp_d[0] = -6; exp_d[1] = 0; exp_d[2] = -12; exp_d[3] = -9;
        do_reset();
        push_row(16, 40, -8, 4);
        pop_n(4, 0);
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== exp_d[k]) begin fails++; $display("FAIL basic_data[%0d] got %0d want %0d", k, got_data[k], exp_d[k]); end
            tests++; if (got_max[k] !== 10) begin fails++; $display("FAIL basic_max[%0d] got %0d want 10", k, got_max[k]); end
            tests++; if (got_last[k] !== (k == 3)) begin fails++; $display("FAIL basic_last[%0d] got %b want %b", k, got_last[k], (k == 3)); end
        end
        tests++; if (first_cyc - acc_cyc !== 2) begin fails++; $display("FAIL basic_latency got %0d want 2", first_cyc - acc_cyc); end
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_after_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_after_ready got %b want 1", bus.in_ready); end
        step();
    endtask

    task automatic test_backpressure();
        logic signed [DW-1:0] exp_d [4];
        exp_d[0] = -6; exp_d[1] = 0; exp_d[2] = -12; exp_d[3] = -9;
        push_row(16, 40, -8, 4);
        pop_n(2, 0);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 999;
            #1;
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", s, bus.out_valid); end
            tests++; if (bus.out_data !== -12) begin fails++; $display("FAIL bp_hold_data[%0d] got %0d want -12", s, bus.out_data); end
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", s, bus.in_ready); end
            step();
        end
        bus.in_valid = 1'b0;
        pop_n(2, 2);
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== exp_d[k]) begin fails++; $display("FAIL bp_data[%0d] got %0d want %0d", k, got_data[k], exp_d[k]); end
        end
        tests++; if (got_last[3] !== 1'b1) begin fails++; $display("FAIL bp_last got %b want 1", got_last[3]); end
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup got %b want 0", bus.out_valid); end
        step();
    endtask

    task automatic test_rounding();
        logic signed [DW-1:0] exp_d [4];
`ifdef SCORE_ROUND_EN
        exp_d[0] = 0; exp_d[1] = -3; exp_d[2] = -2; exp_d[3] = -2;
`else
        exp_d[0] = 0; exp_d[1] = -3; exp_d[2] = -1; exp_d[3] = -1;
`endif
        push_row(6, -6, 0, 0);
        pop_n(4, 0);
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== exp_d[k]) begin fails++; $display("FAIL round_data[%0d] got %0d want %0d", k, got_data[k], exp_d[k]); end
        end
    endtask

    task automatic test_frame_wrap();
        int fd_count;
        fd_count = 0;
        do_reset();
        for (int r = 0; r < 9; r++) begin
            push_row(16, 40, -8, 4);
            pop_n(4, 0);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got_head[k] !== ((r >= 4) && (r < 8))) begin
                    fails++;
                    $display("FAIL wrap_head row %0d elem %0d got %b want %b", r, k, got_head[k], ((r >= 4) && (r < 8)));
                end
                if (got_fd[k]) fd_count++;
            end
            if (r == 7) begin
                tests++; if (got_fd[3] !== 1'b1) begin fails++; $display("FAIL wrap_fd_on_32nd got %b want 1", got_fd[3]); end
            end
        end
        tests++; if (fd_count !== 1) begin fails++; $display("FAIL wrap_fd_count got %0d want 1", fd_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            push_row(16, 40, -8, 4);
            pop_n(4, 0);
        end
        push_row(16, 40, -8, 4);
        pop_n(2, 0);
        tests++; if (got_head[0] !== 1'b1) begin fails++; $display("FAIL mid_head_before got %b want 1", got_head[0]); end
        // Handshake is pending (out_valid && out_ready) while reset is applied.
        bus.out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.out_head !== 1'b0) begin fails++; $display("FAIL mid_out_head got %b want 0", bus.out_head); end
        step();
        push_row(8, 8, 8, 8);
        pop_n(4, 0);
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== 0) begin fails++; $display("FAIL mid_data[%0d] got %0d want 0", k, got_data[k]); end
            tests++; if (got_max[k] !== 2) begin fails++; $display("FAIL mid_max[%0d] got %0d want 2", k, got_max[k]); end
            tests++; if (got_head[k] !== 1'b0) begin fails++; $display("FAIL mid_head[%0d] got %b want 0", k, got_head[k]); end
        end
    endtask

    task automatic test_extremes();
        logic signed [DW-1:0] exp_d [4];
        logic signed [DW-1:0] exp_b [4];
        exp_d[0] = 0;
        exp_d[1] = -32'sd1073741823;
        exp_d[2] = -32'sd536870911;
        exp_d[3] = -32'sd536870911;
        exp_b[0] = -6; exp_b[1] = 0; exp_b[2] = -12; exp_b[3] = -9;
        push_row(32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
        // Junk offered throughout the drain must not be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 555;
        pop_n(4, 0);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== exp_d[k]) begin fails++; $display("FAIL ext_data[%0d] got %0d want %0d", k, got_data[k], exp_d[k]); end
            tests++; if (got_max[k] !== 32'sh1FFF_FFFF) begin fails++; $display("FAIL ext_max[%0d] got %h want 1fffffff", k, got_max[k]); end
        end
        push_row(16, 40, -8, 4);
        pop_n(4, 0);
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_data[k] !== exp_b[k]) begin fails++; $display("FAIL ext_after_data[%0d] got %0d want %0d", k, got_data[k], exp_b[k]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic_row();
        test_backpressure();
        test_rounding();
        test_frame_wrap();
        test_reset_mid();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
